// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Program loader. Encodes symbolic operation requests into 32-bit MIPS
// instruction words and streams them into instruction memory at consecutive
// word addresses. A small FIFO decouples the request side from memory
// back-pressure.
//
// Parameters
//   DEPTH       encoded-word FIFO entries (power of two, >= 2)
//   ADDR_WIDTH  instruction memory word-address width
//   BASE_ADDR   first write address after reset or start
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                rewind: flush FIFO, address/count/err back to initial
//   req_valid/req_ready  request handshake (ready = !full && !start)
//   req_op               0 add, 1 and, 2 or, 3 sub, 4 lw, 5 sw, 6 addi,
//                        7 andi, 8 beq, 9..15 illegal
//   req_rs/rt/rd/imm     instruction fields (rd R-format only, imm I-format only)
//   imem_we/addr/wdata   memory write port (we = FIFO non-empty && !start)
//   imem_ready           memory accepts the write this cycle
//   busy                 FIFO non-empty
//   count                words written since rewind, saturating
//   err                  sticky: an illegal op was accepted
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [4:0]            req_rs,
    input  logic [4:0]            req_rt,
    input  logic [4:0]            req_rd,
    input  logic [15:0]           req_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  imem_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_SUB  = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_ADDI = 4'd6,
        OP_ANDI = 4'd7,
        OP_BEQ  = 4'd8
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SUB = 6'b100010;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_legal;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise unlisted ops would infer a latch.
        enc_word  = '0;
        enc_legal = 1'b1;
        case (req_op)
            OP_ADD:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_ADD};
            OP_AND:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_AND};
            OP_OR:   enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_OR};
            OP_SUB:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_SUB};
            OP_LW:   enc_word = {OPC_LW,    req_rs, req_rt, req_imm};
            OP_SW:   enc_word = {OPC_SW,    req_rs, req_rt, req_imm};
            OP_ADDI: enc_word = {OPC_ADDI,  req_rs, req_rt, req_imm};
            OP_ANDI: enc_word = {OPC_ANDI,  req_rs, req_rt, req_imm};
            OP_BEQ:  enc_word = {OPC_BEQ,   req_rs, req_rt, req_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO state and handshakes
    // ------------------------------------------------------------------
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [OCC_W-1:0] occ;
    logic [31:0]      last_word;
    logic             ready_en;   // low in reset, high from the first edge after release
    logic             full;
    logic             accept;
    logic             push;
    logic             pop;

    assign full       = (occ == OCC_W'(DEPTH));
    assign busy       = (occ != '0);
    assign req_ready  = ready_en && !full && !start;
    assign imem_we    = busy && !start;
    assign accept     = req_valid && req_ready;
    assign push       = accept && enc_legal;    // illegal ops complete the handshake only
    assign pop        = imem_we && imem_ready;
    // The head slot is stable while stalled; when empty, show the last word written.
    assign imem_wdata = busy ? mem[rd_idx] : last_word;

    // NOTE: the storage array has no reset; occupancy is tracked by the reset
    // pointers, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            occ       <= '0;
            last_word <= '0;
            imem_addr <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (start) begin
                // push/pop are already gated off by start; this just rewinds.
                wr_idx    <= '0;
                rd_idx    <= '0;
                occ       <= '0;
                imem_addr <= BASE_ADDR;
                count     <= '0;
                err       <= 1'b0;
            end else begin
                if (push) begin
                    wr_idx <= wr_idx + PTR_W'(1);
                end
                if (pop) begin
                    rd_idx    <= rd_idx + PTR_W'(1);
                    last_word <= mem[rd_idx];
                    imem_addr <= imem_addr + ADDR_WIDTH'(1);  // wraps naturally
                    if (count != '1) begin
                        count <= count + (ADDR_WIDTH + 1)'(1);
                    end
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
                if (accept && !enc_legal) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Scoreboard bench for instr_encoder (DEPTH=4, ADDR_WIDTH=2 so address wrap
// and count saturation are reachable quickly). The driver pushes the expected
// {address, word} of every legal accepted request into a queue; an independent
// monitor pops and compares on each completed memory write.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [4:0]    req_rs = '0;
    logic [4:0]    req_rt = '0;
    logic [4:0]    req_rd = '0;
    logic [15:0]   req_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ready = 1'b0;
    logic          busy;
    logic [AW:0]   count;
    logic          err;

    instr_encoder #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .busy       (busy),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    vec_t          vecs [9];
    exp_t          sb [$];
    logic [AW-1:0] next_addr = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request and hold it until accepted (bounded). Called at posedge+1.
    task automatic send(input vec_t v, input bit legal);
        int n = 0;
        req_valid = 1'b1;
        req_op    = v.op;
        req_rs    = v.rs;
        req_rt    = v.rt;
        req_rd    = v.rd;
        req_imm   = v.imm;
        #1;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: req_ready stayed 0 for op %0d", v.op);
        end else if (legal) begin
            sb.push_back('{addr: next_addr, word: v.word});
            next_addr++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Pulse start for one cycle; checks the forced-low outputs and the rewound state.
    task automatic rewind(input string name);
        start = 1'b1;
        #1;
        check({name, "_start_we"},    32'(imem_we),   32'd0);
        check({name, "_start_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        sb.delete();
        next_addr = '0;
        check({name, "_busy"},  32'(busy),      32'd0);
        check({name, "_addr"},  32'(imem_addr), 32'd0);
        check({name, "_count"}, 32'(count),     32'd0);
        check({name, "_err"},   32'(err),       32'd0);
    endtask

    // Monitor: compare every completed write against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_we && imem_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d word 0x%08h with nothing expected",
                             imem_addr, imem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", imem_wdata, e.word);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // R-formats carry a nonzero imm and I-formats a nonzero rd: both must be ignored.
        vecs[0] = '{op: 4'd0, rs: 5'd1,  rt: 5'd2, rd: 5'd3,  imm: 16'hFFFF, word: 32'h00221820}; // add
        vecs[1] = '{op: 4'd4, rs: 5'd29, rt: 5'd8, rd: 5'd31, imm: 16'h0004, word: 32'h8FA80004}; // lw
        vecs[2] = '{op: 4'd3, rs: 5'd7,  rt: 5'd8, rd: 5'd9,  imm: 16'h0000, word: 32'h00E84822}; // sub
        vecs[3] = '{op: 4'd8, rs: 5'd4,  rt: 5'd5, rd: 5'd0,  imm: 16'hFFFF, word: 32'h1085FFFF}; // beq
        vecs[4] = '{op: 4'd1, rs: 5'd1,  rt: 5'd2, rd: 5'd3,  imm: 16'h0000, word: 32'h00221824}; // and
        vecs[5] = '{op: 4'd2, rs: 5'd1,  rt: 5'd2, rd: 5'd3,  imm: 16'h0000, word: 32'h00221825}; // or
        vecs[6] = '{op: 4'd5, rs: 5'd29, rt: 5'd8, rd: 5'd0,  imm: 16'h0004, word: 32'hAFA80004}; // sw
        vecs[7] = '{op: 4'd6, rs: 5'd1,  rt: 5'd2, rd: 5'd0,  imm: 16'h1234, word: 32'h20221234}; // addi
        vecs[8] = '{op: 4'd7, rs: 5'd1,  rt: 5'd2, rd: 5'd0,  imm: 16'h00FF, word: 32'h302200FF}; // andi

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_we",    32'(imem_we),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata,     32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_err",   32'(err),       32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Encoding sweep, one-cycle latency, address wrap and count saturation
        imem_ready = 1'b1;
        send(vecs[0], 1'b1);
        check("lat_we",    32'(imem_we),   32'd1);
        check("lat_addr",  32'(imem_addr), 32'd0);
        check("lat_wdata", imem_wdata,     32'h00221820);
        for (int i = 1; i < 9; i++) send(vecs[i], 1'b1);
        wait_drain("sweep_drain");
        check("sweep_count_sat", 32'(count),     32'd7);
        check("sweep_addr",      32'(imem_addr), 32'd1);

        // start with words queued: nothing written, state rewound
        imem_ready = 1'b0;
        send(vecs[4], 1'b1);
        send(vecs[5], 1'b1);
        rewind("flush");
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_count", 32'(count), 32'd0);

        // Wrap: 6 words -> addresses 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) send(vecs[i], 1'b1);
        wait_drain("wrap_drain");
        check("wrap_count", 32'(count),     32'd6);
        check("wrap_addr",  32'(imem_addr), 32'd2);

        // Back-pressure: fill the FIFO, head holds, then release
        rewind("bp_rewind");
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[i], 1'b1);
        check("bp_full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_op    = vecs[4].op;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_we",    32'(imem_we),   32'd1);
            check("bp_addr",  32'(imem_addr), 32'd0);
            check("bp_wdata", imem_wdata,     vecs[0].word);
        end
        imem_ready = 1'b1;
        send(vecs[4], 1'b1);
        wait_drain("bp_drain");
        check("bp_count", 32'(count), 32'd5);

        // Illegal op: handshake completes, no write, err sticky until start
        rewind("ill_rewind");
        send('{op: 4'd12, rs: 5'd1, rt: 5'd2, rd: 5'd3, imm: 16'h0000, word: 32'd0}, 1'b0);
        check("ill_err",  32'(err),  32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        send(vecs[7], 1'b1);
        wait_drain("ill_drain");
        check("ill_err_sticky", 32'(err),   32'd1);
        check("ill_count",      32'(count), 32'd1);
        rewind("ill_clear");

        // Async reset mid-stream with 3 words queued
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vecs[i], 1'b1);
        check("ar_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_we_now",   32'(imem_we), 32'd0);
        check("ar_busy_now", 32'(busy),    32'd0);
        sb.delete();
        next_addr = '0;
        #3 rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ar_busy",  32'(busy),      32'd0);
        check("ar_addr",  32'(imem_addr), 32'd0);
        check("ar_count", 32'(count),     32'd0);
        send(vecs[2], 1'b1);
        wait_drain("ar_drain");
        check("ar_count_after", 32'(count), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
